// File: rtl/csr_trap_unit_pkg.sv
// Shared constants for csr_trap_unit: opcodes, CSR addresses, cause codes, mstatus bits, FSM states.
package csr_trap_unit_pkg;

    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_J  = 7'b1101111;
    localparam logic [6:0] OP_JR = 7'b1100111;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    localparam logic [4:0] CAUSE_PC_MIS  = 5'd0;
    localparam logic [4:0] CAUSE_ILLEGAL = 5'd2;
    localparam logic [4:0] CAUSE_BREAK   = 5'd3;
    localparam logic [4:0] CAUSE_LD_MIS  = 5'd4;
    localparam logic [4:0] CAUSE_ST_MIS  = 5'd6;
    localparam logic [4:0] CAUSE_ECALL   = 5'd11;
    localparam logic [4:0] CAUSE_MSI     = 5'd3;
    localparam logic [4:0] CAUSE_MTI     = 5'd7;
    localparam logic [4:0] CAUSE_MEI     = 5'd11;
    localparam int         CAUSE_EXT_BASE = 16;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

endpackage

// File: rtl/csr_trap_arbiter.sv
// Combinational trap priority encoder: exceptions by fixed priority, then masked interrupts.
module csr_trap_arbiter
    import csr_trap_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NUM_EXT_IRQ = 4
) (
    input  logic            valid,
    input  logic            pc_mis,
    input  logic            illegal,
    input  logic            ebreak,
    input  logic            ecall,
    input  logic            ld_mis,
    input  logic            st_mis,
    input  logic            irq_en,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pending,
    output logic            take,
    output logic [XLEN-1:0] cause,
    output logic [XLEN-1:0] mtval
);

    logic [4:0] irq_code;

    always_comb begin
        irq_code = CAUSE_MTI;
        if (pending[11]) begin
            irq_code = CAUSE_MEI;
        end else if (pending[3]) begin
            irq_code = CAUSE_MSI;
        end else if (pending[7]) begin
            irq_code = CAUSE_MTI;
        end else begin
            // Walk downward so the lowest pending platform line ends up selected.
            for (int k = NUM_EXT_IRQ - 1; k >= 0; k--) begin
                if (pending[CAUSE_EXT_BASE + k]) begin
                    irq_code = 5'(CAUSE_EXT_BASE + k);
                end
            end
        end
    end

    always_comb begin
        take  = 1'b0;
        cause = '0;
        mtval = '0;
        if (valid) begin
            if (pc_mis) begin
                take  = 1'b1;
                cause = XLEN'(CAUSE_PC_MIS);
                mtval = alu_result;
            end else if (illegal) begin
                take  = 1'b1;
                cause = XLEN'(CAUSE_ILLEGAL);
            end else if (ebreak) begin
                take  = 1'b1;
                cause = XLEN'(CAUSE_BREAK);
                mtval = pc;
            end else if (ecall) begin
                take  = 1'b1;
                cause = XLEN'(CAUSE_ECALL);
            end else if (ld_mis) begin
                take  = 1'b1;
                cause = XLEN'(CAUSE_LD_MIS);
                mtval = alu_result;
            end else if (st_mis) begin
                take  = 1'b1;
                cause = XLEN'(CAUSE_ST_MIS);
                mtval = alu_result;
            end else if (irq_en && (pending != '0)) begin
                take            = 1'b1;
                cause           = XLEN'(irq_code);
                cause[XLEN-1]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/csr_trap_unit.sv
// M-mode CSR file + trap controller; trap/mret redirects are registered, one cycle after the event, no backpressure.
// Define CSR_COUNTERS_EN to implement mcycle/minstret; otherwise those addresses read 0 and ignore writes.
module csr_trap_unit
    import csr_trap_unit_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              NUM_EXT_IRQ = 4,
    parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0000,
    parameter int              HART_ID     = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic [NUM_EXT_IRQ-1:0] i_ext_irq,
    input  logic                   i_mei,
    input  logic                   i_msi,
    input  logic                   i_mti,
    input  logic                   i_illegal_inst,
    input  logic                   i_ecall,
    input  logic                   i_ebreak,
    input  logic                   i_mret,
    input  logic [6:0]             i_opcode,
    input  logic [2:0]             i_func3,
    input  logic [XLEN-1:0]        i_alu_result,
    input  logic                   i_branch_taken,
    input  logic                   i_csr_en,
    input  logic [11:0]            i_csr_addr,
    input  logic [XLEN-1:0]        i_imm,
    input  logic [XLEN-1:0]        i_rs1,
    input  logic [XLEN-1:0]        i_pc,
    output logic [XLEN-1:0]        o_csr_rdata,
    output logic                   o_csr_illegal,
    output logic                   o_trap,
    output logic [XLEN-1:0]        o_trap_addr,
    output logic                   o_ret_trap,
    output logic [XLEN-1:0]        o_ret_addr
);

    localparam logic [XLEN-1:0] IRQ_MASK =
        XLEN'(32'h0000_0888) | ((((XLEN)'(1) << NUM_EXT_IRQ) - 1) << CAUSE_EXT_BASE);

    state_t          state, state_nx;
    logic            st_mie, st_mpie;
    logic [XLEN-1:0] mie_q, mtvec_q, mepc_q, mcause_q, mtval_q, mscratch_q;
    logic [XLEN-1:0] mip, mstatus_rd;
    logic [XLEN-1:0] trap_addr_q, ret_addr_q;
    logic            ret_trap_q;

    logic [XLEN-1:0] rdata, src, wdata;
    logic            hit, wr_intent, csr_we;
    logic            ls_mis, ld_mis, st_mis, pc_mis;
    logic            take;
    logic [XLEN-1:0] cause, tval, vec_addr;
    logic [1:0]      new_mode;
    logic            unused_imm;

    assign unused_imm = &{1'b0, i_imm[XLEN-1:5]};

    always_comb begin
        mip                                  = '0;
        mip[3]                               = i_msi;
        mip[7]                               = i_mti;
        mip[11]                              = i_mei;
        mip[CAUSE_EXT_BASE +: NUM_EXT_IRQ]   = i_ext_irq;
        mstatus_rd                           = '0;
        mstatus_rd[12:11]                    = 2'b11;
        mstatus_rd[MSTATUS_MPIE]             = st_mpie;
        mstatus_rd[MSTATUS_MIE]              = st_mie;
    end

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q, minstret_q;
`endif

    always_comb begin
        rdata = '0;
        hit   = 1'b1;
        case (i_csr_addr)
            CSR_MSTATUS:   rdata = mstatus_rd;
            CSR_MIE:       rdata = mie_q;
            CSR_MTVEC:     rdata = mtvec_q;
            CSR_MSCRATCH:  rdata = mscratch_q;
            CSR_MEPC:      rdata = mepc_q;
            CSR_MCAUSE:    rdata = mcause_q;
            CSR_MTVAL:     rdata = mtval_q;
            CSR_MIP:       rdata = mip;
            CSR_MHARTID:   rdata = XLEN'(HART_ID);
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:    rdata = mcycle_q[31:0];
            CSR_MCYCLEH:   rdata = mcycle_q[63:32];
            CSR_MINSTRET:  rdata = minstret_q[31:0];
            CSR_MINSTRETH: rdata = minstret_q[63:32];
`else
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: rdata = '0;
`endif
            default:       hit = 1'b0;
        endcase
    end

    assign src = i_func3[2] ? XLEN'(i_imm[4:0]) : i_rs1;

    always_comb begin
        case (i_func3[1:0])
            2'b01:   wdata = src;
            2'b10:   wdata = rdata | src;
            2'b11:   wdata = rdata & ~src;
            default: wdata = rdata;
        endcase
    end

    // Set/clear with a zero source is a pure read, so it is legal even in read-only space.
    assign wr_intent     = (i_func3[1:0] == 2'b01) || ((i_func3[1:0] != 2'b00) && (src != '0));
    assign o_csr_illegal = i_csr_en && (!hit || ((i_csr_addr[11:10] == 2'b11) && wr_intent));
    assign o_csr_rdata   = rdata;

    assign ls_mis = ((i_func3[1:0] == 2'b01) && i_alu_result[0]) ||
                    ((i_func3[1:0] == 2'b10) && (i_alu_result[1:0] != 2'b00));
    assign ld_mis = (i_opcode == OP_LD) && ls_mis;
    assign st_mis = (i_opcode == OP_S) && ls_mis;
    assign pc_mis = ((i_opcode == OP_J) || (i_opcode == OP_JR) ||
                     ((i_opcode == OP_B) && i_branch_taken)) && (i_alu_result[1:0] != 2'b00);

    csr_trap_arbiter #(
        .XLEN        (XLEN),
        .NUM_EXT_IRQ (NUM_EXT_IRQ)
    ) u_arbiter (
        .valid      (i_valid && (state == ST_RUN)),
        .pc_mis     (pc_mis),
        .illegal    (i_illegal_inst || o_csr_illegal),
        .ebreak     (i_ebreak),
        .ecall      (i_ecall),
        .ld_mis     (ld_mis),
        .st_mis     (st_mis),
        .irq_en     (st_mie),
        .alu_result (i_alu_result),
        .pc         (i_pc),
        .pending    (mip & mie_q),
        .take       (take),
        .cause      (cause),
        .mtval      (tval)
    );

    assign csr_we = (state == ST_RUN) && i_valid && i_csr_en && !o_csr_illegal && !take && wr_intent;

    always_comb begin
        vec_addr = {mtvec_q[XLEN-1:2], 2'b00};
        if ((mtvec_q[1:0] == 2'b01) && cause[XLEN-1]) begin
            vec_addr = vec_addr + XLEN'({cause[4:0], 2'b00});
        end
        new_mode = ((wdata[1:0] == 2'b00) || (wdata[1:0] == 2'b01)) ? wdata[1:0] : mtvec_q[1:0];
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_RUN:  if (take) state_nx = ST_TRAP;
            ST_TRAP: state_nx = ST_RUN;
            default: state_nx = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            st_mie      <= 1'b0;
            st_mpie     <= 1'b0;
            mie_q       <= '0;
            mtvec_q     <= MTVEC_RESET;
            mepc_q      <= '0;
            mcause_q    <= '0;
            mtval_q     <= '0;
            mscratch_q  <= '0;
            trap_addr_q <= '0;
            ret_addr_q  <= '0;
            ret_trap_q  <= 1'b0;
        end else begin
            state      <= state_nx;
            ret_trap_q <= 1'b0;
            if ((state == ST_RUN) && take) begin
                mepc_q      <= {i_pc[XLEN-1:2], 2'b00};
                mcause_q    <= cause;
                mtval_q     <= tval;
                st_mpie     <= st_mie;
                st_mie      <= 1'b0;
                trap_addr_q <= vec_addr;
            end else if (csr_we) begin
                case (i_csr_addr)
                    CSR_MSTATUS: begin
                        st_mie  <= wdata[MSTATUS_MIE];
                        st_mpie <= wdata[MSTATUS_MPIE];
                    end
                    CSR_MIE:      mie_q      <= wdata & IRQ_MASK;
                    CSR_MTVEC:    mtvec_q    <= {wdata[XLEN-1:2], new_mode};
                    CSR_MSCRATCH: mscratch_q <= wdata;
                    CSR_MEPC:     mepc_q     <= {wdata[XLEN-1:2], 2'b00};
                    CSR_MCAUSE:   mcause_q   <= wdata;
                    CSR_MTVAL:    mtval_q    <= wdata;
                    default: ;
                endcase
            end
            if ((state == ST_RUN) && i_valid && i_mret && !take) begin
                st_mie     <= st_mpie;
                st_mpie    <= 1'b1;
                ret_trap_q <= 1'b1;
                ret_addr_q <= mepc_q;
            end
        end
    end

`ifdef CSR_COUNTERS_EN
    logic retire;
    assign retire = i_valid && !take && (state == ST_RUN);

    // A write to one half keeps the other half and suppresses that cycle's increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            if (csr_we && (i_csr_addr == CSR_MCYCLE))
                mcycle_q <= {mcycle_q[63:32], wdata};
            else if (csr_we && (i_csr_addr == CSR_MCYCLEH))
                mcycle_q <= {wdata, mcycle_q[31:0]};
            else
                mcycle_q <= mcycle_q + 64'd1;
            if (csr_we && (i_csr_addr == CSR_MINSTRET))
                minstret_q <= {minstret_q[63:32], wdata};
            else if (csr_we && (i_csr_addr == CSR_MINSTRETH))
                minstret_q <= {wdata, minstret_q[31:0]};
            else if (retire)
                minstret_q <= minstret_q + 64'd1;
        end
    end
`endif

    assign o_trap      = (state == ST_TRAP);
    assign o_trap_addr = trap_addr_q;
    assign o_ret_trap  = ret_trap_q;
    assign o_ret_addr  = ret_addr_q;

endmodule
